// File: rtl/mem_arb_pkg.sv
// Shared types and region decode for the memory-port arbiter.
// Build option MEM_ARB_TIMEOUT_EN enables the APB wait timeout.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef OCM_BASE_ADDR
`define OCM_BASE_ADDR 32'h1000_0000
`endif
`ifndef OCM_OFFSET
`define OCM_OFFSET 32'h0000_FFFF
`endif
`ifndef UART0_BASE_ADDR
`define UART0_BASE_ADDR 32'h2000_0000
`endif
`ifndef UART0_OFFSET
`define UART0_OFFSET 32'h0000_0FFF
`endif

package mem_arb_pkg;

  localparam int TIMEOUT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    OCM_RSP,
    APB_WAIT,
    ERR_RSP
  } state_t;

  typedef enum logic [1:0] {
    REG_OCM,
    REG_APB,
    REG_NONE
  } region_t;

  typedef struct packed {
    logic [`XLEN-1:0] lo;
    logic [`XLEN-1:0] hi;
  } bounds_t;

  function automatic region_t decode_region(
    input logic [`XLEN-1:0] addr,
    input bounds_t          ocm,
    input bounds_t          apb
  );
    region_t r;
    r = REG_NONE;
    if (addr >= ocm.lo && addr <= ocm.hi) begin
      r = REG_OCM;
    end else if (addr >= apb.lo && addr <= apb.hi) begin
      r = REG_APB;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer.
// Build option MEM_ARB_TIMEOUT_EN has no effect here.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    int k;
    gnt_o = '0;
    idx_o = '0;
    k     = 0;
    if (en_i) begin
      for (int i = N - 1; i >= 0; i--) begin
        k = (int'(ptr_i) + i) % N;
        if (valid_i[k]) begin
          gnt_o    = '0;
          gnt_o[k] = 1'b1;
          idx_o    = IW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the bridge data-memory port between N_REQ requesters.
// Build option MEM_ARB_TIMEOUT_EN bounds the APB wait.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int               N_REQ          = 2,
  parameter logic [`XLEN-1:0] OCM_LO         = `OCM_BASE_ADDR,
  parameter logic [`XLEN-1:0] OCM_HI         = `OCM_BASE_ADDR + `OCM_OFFSET,
  parameter logic [`XLEN-1:0] APB_LO         = `UART0_BASE_ADDR,
  parameter logic [`XLEN-1:0] APB_HI         = `UART0_BASE_ADDR + `UART0_OFFSET,
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input  logic                     core_clk_i,
  input  logic                     core_resetn_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_write_i,
  input  logic [N_REQ*`XLEN-1:0]   req_addr_i,
  input  logic [N_REQ*`XLEN-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]         resp_valid_o,
  output logic [`XLEN-1:0]         resp_rdata_o,
  output logic                     resp_err_o,
  output logic [`XLEN-1:0]         mem_addr_o,
  output logic                     mem_read_en_o,
  output logic                     mem_write_en_o,
  output logic [`XLEN-1:0]         mem_write_data_o,
  input  logic [`XLEN-1:0]         mem_read_data_i,
  input  logic                     busy_i,
  input  logic                     done_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bounds_t OCM_B = '{lo: OCM_LO, hi: OCM_HI};
  localparam bounds_t APB_B = '{lo: APB_LO, hi: APB_HI};

  state_t           state_q, state_d;
  region_t          reg_q, reg_d, reg_dec;
  logic [IW-1:0]    ptr_q, ptr_d, g_q, g_d, gidx;
  logic [`XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [`XLEN-1:0] sel_addr, sel_wdata;
  logic             wr_q, wr_d, sel_wr;
  logic [N_REQ-1:0] gnt;
  logic             arb_en, apb_done, apb_to, rsp_fire;

  assign arb_en = (state_q == IDLE) && !busy_i && core_resetn_i;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .idx_o   (gidx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx == IW'(k)) begin
        sel_addr  = req_addr_i[k*`XLEN +: `XLEN];
        sel_wdata = req_wdata_i[k*`XLEN +: `XLEN];
        sel_wr    = req_write_i[k];
      end
    end
  end

  assign reg_dec  = decode_region(sel_addr, OCM_B, APB_B);
  assign apb_done = (state_q == APB_WAIT) && done_i;
  assign rsp_fire = (state_q == OCM_RSP) || (state_q == ERR_RSP)
                  || apb_done || apb_to;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign apb_to = (state_q == APB_WAIT) && !done_i
                && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)    cnt_d = '0;
    if (state_q == APB_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge core_clk_i or negedge core_resetn_i) begin
    if (!core_resetn_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end
`else
  assign apb_to = 1'b0;
`endif

  always_ff @(posedge core_clk_i or negedge core_resetn_i) begin
    if (!core_resetn_i) begin
      state_q <= IDLE;
      reg_q   <= REG_OCM;
      ptr_q   <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    g_d     = g_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d = (reg_dec == REG_NONE) ? ERR_RSP : ISSUE;
          reg_d   = reg_dec;
          g_d     = gidx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wr_d    = sel_wr;
        end
      end
      ISSUE:    state_d = (reg_q == REG_OCM) ? OCM_RSP : APB_WAIT;
      OCM_RSP:  state_d = IDLE;
      ERR_RSP:  state_d = IDLE;
      APB_WAIT: if (apb_done || apb_to) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (rsp_fire) begin
      ptr_d = (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
    end
  end

  always_comb begin
    req_ready_o      = '0;
    resp_valid_o     = '0;
    resp_rdata_o     = '0;
    resp_err_o       = 1'b0;
    mem_addr_o       = '0;
    mem_read_en_o    = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_write_data_o = '0;
    unique case (state_q)
      IDLE: req_ready_o = gnt;
      ISSUE: begin
        mem_addr_o       = addr_q;
        mem_write_data_o = wdata_q;
        mem_read_en_o    = !wr_q;
        mem_write_en_o   = wr_q;
      end
      OCM_RSP, APB_WAIT: begin
        mem_addr_o       = addr_q;
        mem_write_data_o = wdata_q;
        if (!apb_to && !wr_q) resp_rdata_o = mem_read_data_i;
        resp_err_o = apb_to;
      end
      ERR_RSP: resp_err_o = 1'b1;
      default: ;
    endcase
    if (rsp_fire) begin
      resp_valid_o = N_REQ'(1) << g_q;
    end else begin
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
    end
  end

endmodule
